// File: rtl/sipo_pkg.sv
// Shared configuration helpers for the multi-lane SIPO deserializer.
// Beat count and beat-counter width are derived from WIDTH/LANES at elaboration.
package sipo_pkg;

    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // Width of the beat counter, i.e. $clog2(BEATS) for a given configuration.
    function automatic int cnt_beat_w(input int width, input int lanes);
        return $clog2(beats(width, lanes));
    endfunction

    function automatic bit cfg_ok(input int width, input int lanes);
        return (width % lanes == 0) && (width >= 2 * lanes) &&
               (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8);
    endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// One-entry valid/ready output register; words arriving while it is full
// and not being drained are dropped and counted.
module sipo_out_buffer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_word,
    input  logic             q_ready,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             drop;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q && !q_ready;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        drop    = 1'b0;

        if (load_valid) begin
            if (!valid_q || q_ready) begin
                q_d     = load_word;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        // A clear wins over a simultaneous drop, which then goes uncounted.
        if (clr_overflow) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != {CNT_W{1'b1}}) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign q          = q_q;
    assign q_valid    = valid_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Multi-lane serial-to-parallel deserializer: collects WIDTH bits over
// WIDTH/LANES qualified beats and hands completed words to a one-entry buffer.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int BEATS      = beats(WIDTH, LANES);
    localparam int CNT_BEAT_W = cnt_beat_w(WIDTH, LANES);
    localparam int HIST_W     = WIDTH - LANES;
    localparam logic [CNT_BEAT_W-1:0] LAST_BEAT = CNT_BEAT_W'(BEATS - 1);

    generate
        if (!cfg_ok(WIDTH, LANES)) begin : g_bad_cfg
            $error("sipo_deserializer: WIDTH must be a multiple of LANES, >= 2*LANES, LANES in {1,2,4,8}");
        end
    endgenerate

    // Only WIDTH-LANES bits of history are kept: the newest beat comes
    // straight from serial_in when the word completes.
    logic [HIST_W-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]      shifted;
    logic [CNT_BEAT_W-1:0] cnt_q, cnt_d;
    logic                  word_done;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {shift_q, serial_in};
            assign shift_d = bit_valid ? shifted[HIST_W-1:0] : shift_q;
        end else begin : g_lsb
            assign shifted = {serial_in, shift_q};
            assign shift_d = bit_valid ? shifted[WIDTH-1:LANES] : shift_q;
        end
    endgenerate

    always_comb begin
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                cnt_d = CNT_BEAT_W'(1);
            end else if (cnt_q == LAST_BEAT) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_BEAT_W'(1);
            end
        end else if (frame_start) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

    sipo_out_buffer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_buffer (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (word_done),
        .load_word    (shifted),
        .q_ready      (q_ready),
        .clr_overflow (clr_overflow),
        .q            (q),
        .q_valid      (q_valid),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: three configurations share control
// inputs; a vector table covers the buffer/overflow path, hand sequences the rest.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] lane_in = '0;
    logic       bv = 1'b0;
    logic       fs = 1'b0;
    logic       rdy = 1'b1;
    logic       clr = 1'b0;

    logic [7:0]  q_m, q_l, drop_m, drop_l, drop_w;
    logic [31:0] q_w;
    logic        qv_m, qv_l, qv_w, ov_m, ov_l, ov_w, busy_m, busy_l, busy_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1), .CNT_W(8)) dut_m (
        .clk(clk), .reset(rst), .serial_in(lane_in[0]), .bit_valid(bv), .frame_start(fs),
        .q(q_m), .q_valid(qv_m), .q_ready(rdy), .overflow(ov_m), .clr_overflow(clr),
        .drop_count(drop_m), .busy(busy_m));

    sipo_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(0), .CNT_W(8)) dut_l (
        .clk(clk), .reset(rst), .serial_in(lane_in[0]), .bit_valid(bv), .frame_start(fs),
        .q(q_l), .q_valid(qv_l), .q_ready(rdy), .overflow(ov_l), .clr_overflow(clr),
        .drop_count(drop_l), .busy(busy_l));

    sipo_deserializer #(.WIDTH(32), .LANES(4), .MSB_FIRST(1), .CNT_W(8)) dut_w (
        .clk(clk), .reset(rst), .serial_in(lane_in), .bit_valid(bv), .frame_start(fs),
        .q(q_w), .q_valid(qv_w), .q_ready(rdy), .overflow(ov_w), .clr_overflow(clr),
        .drop_count(drop_w), .busy(busy_w));

    typedef struct {
        logic       sin;
        logic       bv;
        logic       fs;
        logic       rdy;
        logic       clr;
        logic [7:0] eq;
        logic       eqv;
        logic       eov;
        logic [7:0] edr;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic push(input logic sin, input logic b, input logic f, input logic r, input logic c,
                        input logic [7:0] eq, input logic eqv, input logic eov,
                        input logic [7:0] edr, input logic ebusy);
        vec_t v;
        v.sin = sin; v.bv = b; v.fs = f; v.rdy = r; v.clr = c;
        v.eq = eq; v.eqv = eqv; v.eov = eov; v.edr = edr; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    // Eight MSB-first beats of w; *_dur expected after beats 1..7, *_end after beat 8.
    task automatic push_word(input logic [7:0] w, input logic r, input logic clr_last,
                             input logic [7:0] q_dur, input logic qv_dur, input logic ov_dur,
                             input logic [7:0] dr_dur, input logic [7:0] q_end, input logic qv_end,
                             input logic ov_end, input logic [7:0] dr_end);
        for (int i = 0; i < 8; i++) begin
            if (i == 7)
                push(w[7-i], 1'b1, 1'b0, r, clr_last, q_end, qv_end, ov_end, dr_end, 1'b0);
            else
                push(w[7-i], 1'b1, 1'b0, r, 1'b0, q_dur, qv_dur, ov_dur, dr_dur, 1'b1);
        end
    endtask

    task automatic beat(input logic [3:0] v, input logic f);
        lane_in = v; bv = 1'b1; fs = f;
        @(posedge clk); #1;
        bv = 1'b0; fs = 1'b0;
    endtask

    task automatic idle_cycle(input logic f);
        bv = 1'b0; fs = f;
        @(posedge clk); #1;
        fs = 1'b0;
    endtask

    task automatic send8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) beat({3'b000, w[7-i]}, 1'b0);
    endtask

    task automatic do_reset();
        bv = 1'b0; fs = 1'b0; clr = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq;

        // Reset state of every configuration
        #2;
        check("reset q_m", {24'd0, q_m}, 32'd0);
        check("reset qv_m", {31'd0, qv_m}, 32'd0);
        check("reset busy_m", {31'd0, busy_m}, 32'd0);
        check("reset q_w", q_w, 32'd0);
        check("reset qv_l", {31'd0, qv_l}, 32'd0);
        check("reset drop_w", {24'd0, drop_w}, 32'd0);
        #20;
        rst = 1'b0;

        // Table: 0xA5, one-cycle valid, overflow/drop, clear, clear-vs-drop priority
        push_word(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'hA5, 1'b1, 1'b0, 8'd0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0, 1'b0);
        push_word(8'h11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0, 8'h11, 1'b1, 1'b0, 8'd0);
        push_word(8'h22, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'd0, 8'h11, 1'b1, 1'b1, 8'd1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 8'd1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'd0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'd0, 1'b0);
        push_word(8'h33, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'd0, 8'h33, 1'b1, 1'b0, 8'd0);
        push_word(8'h44, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'd0, 8'h33, 1'b1, 1'b0, 8'd0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            lane_in = {3'b000, vecs[i].sin};
            bv = vecs[i].bv; fs = vecs[i].fs; rdy = vecs[i].rdy; clr = vecs[i].clr;
            @(posedge clk); #1;
            check($sformatf("vec%0d q", i), {24'd0, q_m}, {24'd0, vecs[i].eq});
            check($sformatf("vec%0d q_valid", i), {31'd0, qv_m}, {31'd0, vecs[i].eqv});
            check($sformatf("vec%0d overflow", i), {31'd0, ov_m}, {31'd0, vecs[i].eov});
            check($sformatf("vec%0d drop_count", i), {24'd0, drop_m}, {24'd0, vecs[i].edr});
            check($sformatf("vec%0d busy", i), {31'd0, busy_m}, {31'd0, vecs[i].ebusy});
        end
        clr = 1'b0;

        // LSB-first: 1,0,1,0,0,1,0,1 -> 0xA5, then 1,0,0,0,0,0,0,0 -> 0x01
        do_reset();
        rdy = 1'b1;
        seq = 8'b1010_0101;
        send8(seq);
        check("lsb word1 q", {24'd0, q_l}, 32'h0000_00A5);
        check("lsb word1 q_valid", {31'd0, qv_l}, 32'd1);
        seq = 8'b1000_0000;
        send8(seq);
        check("lsb word2 q", {24'd0, q_l}, 32'h0000_0001);
        check("lsb word2 q_valid", {31'd0, qv_l}, 32'd1);

        // 32-bit x4 lanes, gapped beats
        do_reset();
        rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            beat(4'(k), 1'b0);
            check($sformatf("wide busy after beat %0d", k), {31'd0, busy_w}, (k != 8) ? 32'd1 : 32'd0);
            if (k != 8) begin
                check($sformatf("wide q_valid after beat %0d", k), {31'd0, qv_w}, 32'd0);
                idle_cycle(1'b0);
                check($sformatf("wide busy in gap %0d", k), {31'd0, busy_w}, 32'd1);
            end
        end
        check("wide q", q_w, 32'h1234_5678);
        check("wide q_valid", {31'd0, qv_w}, 32'd1);
        idle_cycle(1'b0);
        check("wide q_valid drained", {31'd0, qv_w}, 32'd0);

        // frame_start: idle resync, then resync on what would be the last beat
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) beat(4'h1, 1'b0);
        check("fs partial busy", {31'd0, busy_m}, 32'd1);
        idle_cycle(1'b1);
        check("fs idle busy", {31'd0, busy_m}, 32'd0);
        for (int i = 0; i < 7; i++) beat(4'h0, 1'b0);
        seq = 8'hC3;
        beat({3'b000, seq[7]}, 1'b1);
        check("fs last-beat no completion", {31'd0, qv_m}, 32'd0);
        check("fs last-beat busy", {31'd0, busy_m}, 32'd1);
        for (int i = 6; i >= 0; i--) beat({3'b000, seq[i]}, 1'b0);
        check("fs word q", {24'd0, q_m}, 32'h0000_00C3);
        check("fs word q_valid", {31'd0, qv_m}, 32'd1);

        // Asynchronous reset mid-word with a buffered word and a drop recorded
        do_reset();
        rdy = 1'b0;
        send8(8'hFF);
        send8(8'h0F);
        for (int i = 0; i < 5; i++) beat(4'h1, 1'b0);
        check("pre-reset q", {24'd0, q_m}, 32'h0000_00FF);
        check("pre-reset overflow", {31'd0, ov_m}, 32'd1);
        check("pre-reset busy", {31'd0, busy_m}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset q", {24'd0, q_m}, 32'd0);
        check("async reset q_valid", {31'd0, qv_m}, 32'd0);
        check("async reset overflow", {31'd0, ov_m}, 32'd0);
        check("async reset drop_count", {24'd0, drop_m}, 32'd0);
        check("async reset busy", {31'd0, busy_m}, 32'd0);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
        idle_cycle(1'b0);
        check("post-reset idle q_valid", {31'd0, qv_m}, 32'd0);
        send8(8'h5A);
        check("post-reset q", {24'd0, q_m}, 32'h0000_005A);
        check("post-reset q_valid", {31'd0, qv_m}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
